// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester above ptr wins.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  // Walk from farthest to nearest so the nearest requester after ptr wins
  always_comb begin
    int   idx_s;
    logic hit_s;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx_s   = 0;
    hit_s   = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx_s   = (int'(ptr) + i) % NUM_CH;
      hit_s   = req[idx_s];
      gnt_idx = hit_s ? SEL_W'(idx_s) : gnt_idx;
      gnt_vld = gnt_vld | hit_s;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel packet-locking stream multiplexer with fixed or round-robin
// channel selection and a registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = idx_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     rr_en,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     busy
);

  state_t              state_r;
  logic [SEL_W-1:0]    g_r;
  logic [SEL_W-1:0]    ptr_r;
  logic                out_valid_r;
  logic [DATA_W-1:0]   out_data_r;
  logic                out_last_r;
  logic [SEL_W-1:0]    out_ch_r;

  logic [NUM_CH-1:0]   sel_oh_s;
  logic [NUM_CH-1:0]   arb_req_s;
  logic [NUM_CH-1:0]   in_ready_s;
  logic [SEL_W-1:0]    gnt_idx_s;
  logic                gnt_vld_s;
  logic                lock_s;
  logic                slot_free_s;
  logic                accept_s;
  logic [DATA_W-1:0]   beat_data_s;
  logic                beat_last_s;

  // Out-of-range sel decodes to no request at all
  always_comb begin
    sel_oh_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_oh_s[k] = (int'(sel) == k);
    end
  end

  assign arb_req_s = rr_en ? in_valid : (in_valid & sel_oh_s);

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req     (arb_req_s),
    .ptr     (ptr_r),
    .gnt_idx (gnt_idx_s),
    .gnt_vld (gnt_vld_s)
  );

  assign lock_s      = (state_r == ST_LOCK);
  assign slot_free_s = !out_valid_r || out_ready;

  // Ready to the granted channel only, plus the granted channel's beat
  always_comb begin
    in_ready_s  = '0;
    beat_data_s = '0;
    beat_last_s = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      in_ready_s[k] = lock_s && slot_free_s && (int'(g_r) == k);
      beat_data_s   = (int'(g_r) == k) ? in_data[k*DATA_W +: DATA_W] : beat_data_s;
      beat_last_s   = (int'(g_r) == k) ? in_last[k] : beat_last_s;
    end
  end

  assign accept_s = |(in_valid & in_ready_s);

  // Grant / packet-lock FSM; ptr remembers the last served channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      g_r     <= '0;
      ptr_r   <= SEL_W'(NUM_CH - 1);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gnt_vld_s) begin
            g_r     <= gnt_idx_s;
            state_r <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (accept_s && beat_last_s) begin
            ptr_r   <= g_r;
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Output register: load on accept, drain when consumer takes the beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_ch_r    <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= beat_data_s;
      out_last_r  <= beat_last_s;
      out_ch_r    <= g_r;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign out_ch    = out_ch_r;
  assign busy      = lock_s;

endmodule
